// File: rtl/bpsk_phase_modulator.sv
// bpsk_phase_modulator: coherent BPSK phase word plus a sinc-gated amplitude envelope.
// BPSK_ENVELOPE_RAMP_EN builds the ramped envelope; otherwise the envelope switches on and off in one step.
module bpsk_phase_modulator #(
    parameter int PHASE_W = 32,
    parameter int AMP_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sinc,
    input  logic               code_bit,
    input  logic [PHASE_W-1:0] tuning_word,
    input  logic [AMP_W-1:0]   amp_max,
    input  logic [AMP_W-1:0]   ramp_step,
    output logic [PHASE_W-1:0] phase_out,
    output logic [AMP_W-1:0]   amp_out,
    output logic               tx_active,
    output logic               tx_done
);
    typedef enum logic [1:0] {IDLE, RAMP_UP, HOLD, RAMP_DOWN} state_t;
    state_t state_q, state_d;
    logic [PHASE_W-1:0] acc_q, acc_d, phase_q, phase_d;
    logic [AMP_W-1:0] amp_q, amp_d;
    logic active_q, active_d, done_q, done_d;
`ifdef BPSK_ENVELOPE_RAMP_EN
    logic [AMP_W-1:0] amax_q, amax_d, step_q, step_d;
    logic [AMP_W-1:0] up_base, up_step, up_max, up_amp, dn_amp;
    logic [AMP_W:0] up_sum;
    logic go_down;
    always_comb begin
        // From IDLE the first step uses the live inputs, since they are being latched on this edge.
        up_base = (state_q == IDLE) ? '0 : amp_q;
        up_step = (state_q == IDLE) ? ramp_step : step_q;
        up_max  = (state_q == IDLE) ? amp_max : amax_q;
        up_sum  = {1'b0, up_base} + {1'b0, up_step};
        up_amp  = (up_step == '0 || up_sum >= {1'b0, up_max}) ? up_max : up_sum[AMP_W-1:0];
        dn_amp  = (step_q != '0 && amp_q > step_q) ? amp_q - step_q : '0;
        go_down = (state_q == RAMP_DOWN) || (state_q != IDLE && !sinc);
    end
`else
    logic unused_step;
    assign unused_step = ^ramp_step;
`endif
    always_comb begin
        state_d = state_q;
        amp_d   = amp_q;
        done_d  = 1'b0;
        acc_d   = acc_q + tuning_word;
        phase_d = acc_q + {code_bit, {(PHASE_W-1){1'b0}}};
`ifdef BPSK_ENVELOPE_RAMP_EN
        amax_d = amax_q;
        step_d = step_q;
        if (go_down) begin
            amp_d   = dn_amp;
            state_d = (dn_amp == '0) ? IDLE : RAMP_DOWN;
            done_d  = (dn_amp == '0);
        end else if (sinc) begin
            // HOLD with sinc high re-evaluates to amax, so it shares the ramp-up path.
            amp_d   = up_amp;
            state_d = (state_q != IDLE && up_amp == amax_q) ? HOLD : RAMP_UP;
            amax_d  = (state_q == IDLE) ? amp_max : amax_q;
            step_d  = (state_q == IDLE) ? ramp_step : step_q;
        end
`else
        if (state_q == IDLE && sinc) begin
            state_d = HOLD;
            amp_d   = amp_max;
        end else if (state_q != IDLE && !sinc) begin
            state_d = IDLE;
            amp_d   = '0;
            done_d  = 1'b1;
        end
`endif
        active_d = (state_d != IDLE);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            phase_q  <= '0;
            amp_q    <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
`ifdef BPSK_ENVELOPE_RAMP_EN
            amax_q   <= '0;
            step_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            phase_q  <= phase_d;
            amp_q    <= amp_d;
            active_q <= active_d;
            done_q   <= done_d;
`ifdef BPSK_ENVELOPE_RAMP_EN
            amax_q   <= amax_d;
            step_q   <= step_d;
`endif
        end
    end
    assign phase_out = phase_q;
    assign amp_out   = amp_q;
    assign tx_active = active_q;
    assign tx_done   = done_q;
endmodule

// File: doc/bpsk_phase_modulator.md
Name: bpsk_phase_modulator

Overview:
- Transmit-chain stage directly downstream of the phase-code generator.
- Consumes the serial code bit and the `sinc` transmit gate.
- Produces a BPSK phase word and an amplitude envelope for the DDS/DAC path.
- Phase comes from a free-running, coherent phase accumulator plus a pi offset when the code bit is 1; amplitude is a gated, ramped envelope.

Parameters:
PHASE_W, 32, phase accumulator and phase_out width
AMP_W, 16, amplitude/envelope width (unsigned)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
sinc  in  1  transmit gate; high = pulse window
code_bit  in  1  phase-code bit from code generator; 1 = add pi
tuning_word  in  PHASE_W  phase increment per clk (carrier frequency)
amp_max  in  AMP_W  envelope plateau level
ramp_step  in  AMP_W  envelope increment/decrement per clk
phase_out  out  PHASE_W  modulated phase word to DDS
amp_out  out  AMP_W  envelope amplitude
tx_active  out  1  high whenever FSM not IDLE
tx_done  out  1  one-cycle pulse when envelope returns to IDLE

Behaviour:
- Reset (rst=1 at clk edge): accumulator=0, phase_out=0, amp_out=0, tx_active=0, tx_done=0, FSM=IDLE, latched config=0. Reset mid-pulse aborts immediately; no ramp-down.
- Phase accumulator: acc <= acc + tuning_word every cycle, including in IDLE, so pulses stay coherent. Wraps modulo 2^PHASE_W; no saturation.
- tuning_word is sampled every cycle; it is not latched.
- phase_out <= acc + (code_bit ? 2^(PHASE_W-1) : 0), registered. Latency: code_bit change → phase_out change in 1 cycle.
- phase_out is driven in all states; amp_out is the gate.
- amp_max and ramp_step are latched on the IDLE→RAMP_UP transition and held constant for the whole pulse.
- FSM states: IDLE, RAMP_UP, HOLD, RAMP_DOWN.
- IDLE:
  - amp_out=0.
  - sinc=1 → RAMP_UP; latch config.
- RAMP_UP:
  - amp <= min(amp + step, amp_max), with the sum computed at AMP_W+1 bits (no overflow).
  - When the result equals amp_max → HOLD.
  - sinc=0 → RAMP_DOWN from the current amp; this check has priority over the plateau check.
- HOLD:
  - amp_out=amp_max.
  - sinc=0 → RAMP_DOWN.
- RAMP_DOWN:
  - amp <= (amp > step) ? amp - step : 0.
  - When the result is 0 → IDLE, and tx_done=1 for that one cycle.
  - sinc is ignored in this state.
  - A new pulse starts only from IDLE; if sinc is still high on arrival in IDLE, RAMP_UP begins the next cycle.
- Boundary cases:
  - ramp_step=0: treated as an instant step; amp jumps directly to amp_max (up) or 0 (down).
  - amp_max=0: RAMP_UP → HOLD after one cycle with amp 0, to avoid a stuck ramp.
- tx_active = (state != IDLE), registered alongside the state.

Optional Feature:
Macro: BPSK_ENVELOPE_RAMP_EN
- Defined: full ramped envelope as above.
- Undefined:
  - RAMP_UP and RAMP_DOWN are not built; ramp_step is ignored.
  - IDLE → HOLD on sinc=1, with amp_out=amp_max the next cycle.
  - HOLD → IDLE on sinc=0, with amp_out=0 and tx_done=1 the next cycle.
  - Phase path is identical in both builds.

Test Plan:
- Reset with rst=1 for 3 cycles, tuning_word=0x10000000 → phase_out=0 and amp_out=0 during reset. After release, phase_out steps 0x00000000, 0x10000000, 0x20000000… (1-cycle register lag). Accumulator wraps to 0 after 16 cycles.
- tuning_word=0, code_bit toggling 0,1,1,0 → phase_out = 0, 0x80000000, 0x80000000, 0 (each delayed 1 cycle).
- Ramp build, amp_max=100, ramp_step=30, sinc high 10 cycles → amp_out 30, 60, 90, 100 (HOLD). Then after sinc falls: 70, 40, 10, 0, with tx_done=1 on the 0 cycle. tx_active high throughout.
- Early sinc drop, amp_max=1000, ramp_step=100, sinc high 3 cycles → amp rises 100, 200, 300, then falls 200, 100, 0. HOLD is never entered.
- Re-trigger during RAMP_DOWN: sinc re-asserted while amp=40, step=30 → ramp continues 10, 0 (IDLE, tx_done). The next cycle enters RAMP_UP and amp=30.
- Mid-pulse reset in HOLD with amp=100 → the next cycle shows amp_out=0, tx_active=0, tx_done=0, FSM IDLE. Rerun with the macro undefined: sinc high gives amp_out=amp_max one cycle later.
